// File: rtl/pcie_perst_seq.sv
// -----------------------------------------------------------------------------
// pcie_perst_seq
//
// Purpose: drives PERST# to a PCIe hard IP / endpoint and supervises link
// training. PERST# is held low for PERST_ASSERT_CYC cycles, then released.
// The block then waits up to LINK_TIMEOUT_CYC cycles for linkup and dlup.
// A timeout re-asserts PERST# and retries up to MAX_RETRIES times before
// parking in FAIL. A link drop or surprise-down while up restarts the
// sequence and counts a link-down event.
//
// Optional feature macro: PCIE_PERST_SEQ_DOWN_CNT_EN
//   defined   - down_cnt is an 8-bit link-down counter saturating at 255
//   undefined - down_cnt is tied to zero
//
// Ports:
//   clk                   in   sole clock
//   reset                 in   asynchronous, active-high reset
//   restart               in   pulse, forces a fresh sequence
//   serr_clr              in   pulse, clears serr_seen
//   app_linkup            in   HIP linkup (asynchronous)
//   app_dlup              in   HIP data-link up (asynchronous)
//   app_serr              in   HIP system error (asynchronous)
//   app_surprise_down_err in   HIP surprise-down (asynchronous)
//   perst_n               out  PERST# to HIP/endpoint
//   link_ok               out  link up and stable
//   link_fail             out  retries exhausted
//   serr_seen             out  sticky system error flag
//   retry_cnt             out  timeouts in the current sequence
//   down_cnt              out  link-down events
//   state                 out  encoded FSM state
//
// state | meaning
// ------+---------------------------------------------------------
// 0     | ASSERT    : PERST# low, timing the assertion window
// 1     | WAIT_LINK : PERST# high, waiting for linkup and dlup
// 2     | UP        : link trained, link_ok high
// 3     | FAIL      : retries exhausted, PERST# low until restart
// -----------------------------------------------------------------------------
module pcie_perst_seq #(
    parameter int PERST_ASSERT_CYC = 100000,
    parameter int LINK_TIMEOUT_CYC = 10000000,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       serr_clr,
    input  logic       app_linkup,
    input  logic       app_dlup,
    input  logic       app_serr,
    input  logic       app_surprise_down_err,
    output logic       perst_n,
    output logic       link_ok,
    output logic       link_fail,
    output logic       serr_seen,
    output logic [3:0] retry_cnt,
    output logic [7:0] down_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_ASSERT    = 3'd0,
        S_WAIT_LINK = 3'd1,
        S_UP        = 3'd2,
        S_FAIL      = 3'd3
    } state_t;

    localparam logic [23:0] PERST_LAST   = 24'(PERST_ASSERT_CYC - 1);
    localparam logic [23:0] LINK_LAST    = 24'(LINK_TIMEOUT_CYC - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    // Synchronizer bit map: 0 linkup, 1 dlup, 2 serr, 3 surprise-down
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic       linkup_s;
    logic       dlup_s;
    logic       serr_s;
    logic       sdown_s;

    state_t     state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic [3:0] retry_q, retry_d;
    logic       perst_n_q;
    logic       link_ok_q;
    logic       link_fail_q;
    logic       serr_q, serr_d;
    logic       down_evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {app_surprise_down_err, app_serr, app_dlup, app_linkup};
            sync2_q <= sync1_q;
        end
    end

    assign linkup_s = sync2_q[0];
    assign dlup_s   = sync2_q[1];
    assign serr_s   = sync2_q[2];
    assign sdown_s  = sync2_q[3];

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        down_evt = 1'b0;
        if (restart) begin
            state_d = S_ASSERT;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_ASSERT: begin
                    if (timer_q == PERST_LAST) begin
                        state_d = S_WAIT_LINK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 24'd1;
                    end
                end
                S_WAIT_LINK: begin
                    // Link-up is tested first so it wins over a coincident timeout
                    if (linkup_s && dlup_s) begin
                        state_d = S_UP;
                        timer_d = '0;
                        retry_d = '0;
                    end else if (timer_q == LINK_LAST) begin
                        timer_d = '0;
                        if (retry_q < RETRY_LIMIT) begin
                            retry_d = retry_q + 4'd1;
                            state_d = S_ASSERT;
                        end else begin
                            state_d = S_FAIL;
                        end
                    end else begin
                        timer_d = timer_q + 24'd1;
                    end
                end
                S_UP: begin
                    if (!linkup_s || sdown_s) begin
                        state_d  = S_ASSERT;
                        timer_d  = '0;
                        retry_d  = '0;
                        down_evt = 1'b1;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_ASSERT;
                    timer_d = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Set has priority over clear so a coincident error is never lost
    assign serr_d = serr_s | (serr_q & ~serr_clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_ASSERT;
            timer_q     <= '0;
            retry_q     <= '0;
            perst_n_q   <= 1'b0;
            link_ok_q   <= 1'b0;
            link_fail_q <= 1'b0;
            serr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            // Outputs decoded from next state so they align with state
            perst_n_q   <= (state_d == S_WAIT_LINK) || (state_d == S_UP);
            link_ok_q   <= (state_d == S_UP);
            link_fail_q <= (state_d == S_FAIL);
            serr_q      <= serr_d;
        end
    end

`ifdef PCIE_PERST_SEQ_DOWN_CNT_EN
    logic [7:0] down_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            down_q <= '0;
        end else if (down_evt && (down_q != 8'hFF)) begin
            down_q <= down_q + 8'd1;
        end
    end

    assign down_cnt = down_q;
`else
    logic unused_down_evt;
    assign unused_down_evt = down_evt;
    assign down_cnt        = 8'd0;
`endif

    assign perst_n   = perst_n_q;
    assign link_ok   = link_ok_q;
    assign link_fail = link_fail_q;
    assign serr_seen = serr_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pcie_perst_seq.sv
module tb_pcie_perst_seq;

    localparam int PA = 4;
    localparam int LT = 16;
    localparam int MR = 2;
`ifdef PCIE_PERST_SEQ_DOWN_CNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       serr_clr = 1'b0;
    logic       app_linkup = 1'b0;
    logic       app_dlup = 1'b0;
    logic       app_serr = 1'b0;
    logic       app_surprise_down_err = 1'b0;
    logic       perst_n;
    logic       link_ok;
    logic       link_fail;
    logic       serr_seen;
    logic [3:0] retry_cnt;
    logic [7:0] down_cnt;
    logic [2:0] state;

    int n_chk = 0;
    int n_fail = 0;

    pcie_perst_seq #(
        .PERST_ASSERT_CYC(PA),
        .LINK_TIMEOUT_CYC(LT),
        .MAX_RETRIES(MR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .restart(restart),
        .serr_clr(serr_clr),
        .app_linkup(app_linkup),
        .app_dlup(app_dlup),
        .app_serr(app_serr),
        .app_surprise_down_err(app_surprise_down_err),
        .perst_n(perst_n),
        .link_ok(link_ok),
        .link_fail(link_fail),
        .serr_seen(serr_seen),
        .retry_cnt(retry_cnt),
        .down_cnt(down_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs, lu, dl, sd, se, clr;
        int         st, p, ok, fl, sv, rt, dn;
    } vec_t;

    vec_t tbl[16];

    // Reference model: phase name, cycles spent in phase, and two-edge input history
    int m_ph, m_el, m_rt, m_dn, m_sv;
    logic [3:0] m_h1, m_h2;

    function automatic int edn(input int n);
        return DC_EN ? ((n > 255) ? 255 : n) : 0;
    endfunction

    function automatic vec_t mk(input logic rs, lu, dl, sd, se, clr,
                                input int st, sv, dn);
        vec_t v;
        v.rs = rs; v.lu = lu; v.dl = dl; v.sd = sd; v.se = se; v.clr = clr;
        v.st = st;
        v.p  = (st == 1 || st == 2) ? 1 : 0;
        v.ok = (st == 2) ? 1 : 0;
        v.fl = (st == 3) ? 1 : 0;
        v.sv = sv; v.rt = 0; v.dn = edn(dn);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ph = 0; m_el = 0; m_rt = 0; m_dn = 0; m_sv = 0;
        m_h1 = '0; m_h2 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        restart = 0; serr_clr = 0; app_linkup = 0; app_dlup = 0;
        app_serr = 0; app_surprise_down_err = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Advances the model by one clock using the inputs that the DUT just sampled
    task automatic model_step();
        logic lu, dl, se, sd;
        lu = m_h2[0]; dl = m_h2[1]; se = m_h2[2]; sd = m_h2[3];
        if (restart) begin
            m_ph = 0; m_el = 0; m_rt = 0;
        end else if (m_ph == 0) begin
            m_el++;
            if (m_el == PA) begin m_ph = 1; m_el = 0; end
        end else if (m_ph == 1) begin
            m_el++;
            if (lu && dl) begin
                m_ph = 2; m_el = 0; m_rt = 0;
            end else if (m_el == LT) begin
                m_el = 0;
                if (m_rt < MR) begin m_rt++; m_ph = 0; end
                else m_ph = 3;
            end
        end else if (m_ph == 2) begin
            if (!lu || sd) begin
                m_ph = 0; m_el = 0; m_rt = 0;
                m_dn = (m_dn < 255) ? m_dn + 1 : 255;
            end
        end
        m_sv = (se || (m_sv != 0 && !serr_clr)) ? 1 : 0;
        m_h2 = m_h1;
        m_h1 = {app_surprise_down_err, app_serr, app_dlup, app_linkup};
    endtask

    task automatic cmp_model(input int cyc);
        chk($sformatf("rnd_state[%0d]", cyc), int'(state), m_ph);
        chk($sformatf("rnd_perst[%0d]", cyc), int'(perst_n), (m_ph == 1 || m_ph == 2) ? 1 : 0);
        chk($sformatf("rnd_ok[%0d]", cyc), int'(link_ok), (m_ph == 2) ? 1 : 0);
        chk($sformatf("rnd_fail[%0d]", cyc), int'(link_fail), (m_ph == 3) ? 1 : 0);
        chk($sformatf("rnd_serr[%0d]", cyc), int'(serr_seen), m_sv);
        chk($sformatf("rnd_retry[%0d]", cyc), int'(retry_cnt), m_rt);
        chk($sformatf("rnd_down[%0d]", cyc), int'(down_cnt), edn(m_dn));
    endtask

    initial begin
        int rises, low_len, wcnt;
        bit reached;

        // rows: rs lu dl sd se clr | state serr down
        tbl[0]  = mk(0,0,0,0,0,0, 0,0,0);
        tbl[1]  = mk(0,0,0,0,0,0, 0,0,0);
        tbl[2]  = mk(0,0,0,0,0,0, 0,0,0);
        tbl[3]  = mk(0,0,0,0,0,0, 1,0,0);
        tbl[4]  = mk(0,1,1,0,1,0, 1,0,0);
        tbl[5]  = mk(0,1,1,0,0,0, 1,0,0);
        tbl[6]  = mk(0,1,1,0,0,1, 2,1,0);
        tbl[7]  = mk(0,1,1,0,0,1, 2,0,0);
        tbl[8]  = mk(0,1,1,1,0,0, 2,0,0);
        tbl[9]  = mk(0,1,1,0,0,0, 2,0,0);
        tbl[10] = mk(0,1,1,0,0,0, 0,0,1);
        tbl[11] = mk(0,1,1,0,0,0, 0,0,1);
        tbl[12] = mk(0,1,1,0,0,0, 0,0,1);
        tbl[13] = mk(0,1,1,0,0,0, 0,0,1);
        tbl[14] = mk(0,1,1,0,0,0, 1,0,1);
        tbl[15] = mk(0,1,1,0,0,0, 2,0,1);

        // Reset state
        do_reset();
        chk("rst_state", int'(state), 0);
        chk("rst_perst", int'(perst_n), 0);
        chk("rst_ok", int'(link_ok), 0);
        chk("rst_fail", int'(link_fail), 0);
        chk("rst_down", int'(down_cnt), 0);

        // Table: bring-up, serr set/clear race, surprise-down and re-training
        for (int i = 0; i < 16; i++) begin
            restart = tbl[i].rs; app_linkup = tbl[i].lu; app_dlup = tbl[i].dl;
            app_surprise_down_err = tbl[i].sd; app_serr = tbl[i].se; serr_clr = tbl[i].clr;
            step();
            chk($sformatf("tbl_state[%0d]", i), int'(state), tbl[i].st);
            chk($sformatf("tbl_perst[%0d]", i), int'(perst_n), tbl[i].p);
            chk($sformatf("tbl_ok[%0d]", i), int'(link_ok), tbl[i].ok);
            chk($sformatf("tbl_fail[%0d]", i), int'(link_fail), tbl[i].fl);
            chk($sformatf("tbl_serr[%0d]", i), int'(serr_seen), tbl[i].sv);
            chk($sformatf("tbl_retry[%0d]", i), int'(retry_cnt), tbl[i].rt);
            chk($sformatf("tbl_down[%0d]", i), int'(down_cnt), tbl[i].dn);
        end

        // Link never comes up: three PERST# pulses, then FAIL
        do_reset();
        rises = 0; low_len = 0;
        for (int e = 1; e <= 64; e++) begin
            logic prev;
            prev = perst_n;
            step();
            if (!perst_n) low_len++;
            if (perst_n && !prev) begin
                rises++;
                if (rises > 1) chk($sformatf("to_pulse_len[%0d]", rises), low_len, PA);
                low_len = 0;
            end
            if (e == 4)  chk("to_first_rise", int'(perst_n), 1);
            if (e == 20) chk("to_retry1", int'(retry_cnt), 1);
            if (e == 20) chk("to_state_e20", int'(state), 0);
            if (e == 40) chk("to_retry2", int'(retry_cnt), 2);
            if (e == 59) chk("to_fail_e59", int'(link_fail), 0);
            if (e == 60) begin
                chk("to_fail_e60", int'(link_fail), 1);
                chk("to_state_e60", int'(state), 3);
                chk("to_perst_e60", int'(perst_n), 0);
            end
        end
        chk("to_rises", rises, 3);
        chk("to_fail_hold", int'(link_fail), 1);
        chk("to_retry_hold", int'(retry_cnt), 2);

        // Restart out of FAIL
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rs_state", int'(state), 0);
        chk("rs_retry", int'(retry_cnt), 0);
        chk("rs_fail", int'(link_fail), 0);
        app_linkup = 1'b1; app_dlup = 1'b1;
        reached = 0;
        for (wcnt = 0; wcnt < 20 && !reached; wcnt++) begin
            step();
            if (state == 3'd2) reached = 1;
        end
        chk("rs_reach_up", int'(reached), 1);
        chk("rs_up_cycles", wcnt, PA + 1);
        chk("rs_ok", int'(link_ok), 1);
        chk("rs_fail_low", int'(link_fail), 0);

        // 300 surprise-down events: counter saturates
        for (int k = 0; k < 300; k++) begin
            reached = 0;
            for (int w = 0; w < 20 && !reached; w++) begin
                if (state == 3'd2) reached = 1;
                else step();
            end
            if (!reached) begin
                chk("sat_wait_up", 0, 1);
                break;
            end
            app_surprise_down_err = 1'b1;
            step();
            app_surprise_down_err = 1'b0;
            step();
            if (k == 0) chk("sd_not_yet", int'(state), 2);
            step();
            if (k == 0) begin
                chk("sd_state", int'(state), 0);
                chk("sd_ok", int'(link_ok), 0);
                chk("sd_down1", int'(down_cnt), edn(1));
            end
        end
        chk("sat_down", int'(down_cnt), edn(300));

        // Reset mid-WAIT_LINK takes effect without a clock edge
        app_linkup = 1'b0; app_dlup = 1'b0;
        reached = 0;
        for (int w = 0; w < 20 && !reached; w++) begin
            step();
            if (state == 3'd1) reached = 1;
        end
        chk("ar_reach_wait", int'(reached), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_state", int'(state), 0);
        chk("ar_perst", int'(perst_n), 0);
        chk("ar_ok", int'(link_ok), 0);
        chk("ar_fail", int'(link_fail), 0);
        chk("ar_serr", int'(serr_seen), 0);
        chk("ar_retry", int'(retry_cnt), 0);
        chk("ar_down", int'(down_cnt), 0);

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            restart  = ($urandom_range(0, 99) == 0);
            serr_clr = ($urandom_range(0, 7) == 0);
            app_serr = ($urandom_range(0, 29) == 0);
            app_surprise_down_err = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 24) == 0) app_linkup = ~app_linkup;
            if ($urandom_range(0, 24) == 0) app_dlup = ~app_dlup;
            step();
            model_step();
            cmp_model(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
